// File: rtl/ifetch_data_stage_pkg.sv
// Shared sizes, address types and fault classification for the L1 instruction
// cache data stage.
package ifetch_data_stage_pkg;

    localparam int L1I_WAYS         = 4;
    localparam int L1I_SETS         = 64;
    localparam int CACHE_LINE_BITS  = 512;
    localparam int CACHE_LINE_BYTES = CACHE_LINE_BITS / 8;
    localparam int CACHE_LINE_WORDS = CACHE_LINE_BITS / 32;
    localparam int THREADS_PER_CORE = 4;

    localparam int CACHE_LINE_OFFSET_WIDTH = $clog2(CACHE_LINE_BYTES);
    localparam int L1I_SET_IDX_WIDTH       = $clog2(L1I_SETS);
    localparam int L1I_WAY_IDX_WIDTH       = $clog2(L1I_WAYS);
    localparam int L1I_TAG_WIDTH           = 32 - L1I_SET_IDX_WIDTH - CACHE_LINE_OFFSET_WIDTH;
    localparam int THREAD_IDX_WIDTH        = $clog2(THREADS_PER_CORE);

    typedef logic [L1I_TAG_WIDTH-1:0]     l1i_tag_t;
    typedef logic [L1I_SET_IDX_WIDTH-1:0] l1i_set_idx_t;
    typedef logic [L1I_WAY_IDX_WIDTH-1:0] l1i_way_idx_t;
    typedef logic [THREAD_IDX_WIDTH-1:0]  local_thread_idx_t;
    typedef logic [31-CACHE_LINE_OFFSET_WIDTH:0] cache_line_index_t;

    typedef struct packed {
        l1i_tag_t                           tag;
        l1i_set_idx_t                       set_idx;
        logic [CACHE_LINE_OFFSET_WIDTH-1:0] offset;
    } l1i_addr_t;

    typedef enum logic [2:0] {
        FAULT_NONE,
        FAULT_ALIGNMENT,
        FAULT_TLB_MISS,
        FAULT_PAGE,
        FAULT_SUPERVISOR,
        FAULT_EXECUTABLE
    } fetch_fault_t;

    // Only the most important fault is reported, so the checks are ordered.
    function automatic fetch_fault_t classify_fault(
        input logic misaligned,
        input logic tlb_hit,
        input logic present,
        input logic supervisor_violation,
        input logic executable
    );
        if (misaligned)
            return FAULT_ALIGNMENT;
        else if (!tlb_hit)
            return FAULT_TLB_MISS;
        else if (!present)
            return FAULT_PAGE;
        else if (supervisor_violation)
            return FAULT_SUPERVISOR;
        else if (!executable)
            return FAULT_EXECUTABLE;
        else
            return FAULT_NONE;
    endfunction

endpackage

// File: rtl/ifetch_data_stage_if.sv
// Request from the fetch tag stage plus the same-cycle miss/LRU feedback the
// data stage returns to it.
interface ifetch_data_stage_if import ifetch_data_stage_pkg::*; ();

    logic              ift_instruction_requested;
    l1i_addr_t         ift_pc_paddr;
    logic [31:0]       ift_pc_vaddr;
    local_thread_idx_t ift_thread_idx;
    logic              ift_tlb_hit;
    logic              ift_tlb_present;
    logic              ift_tlb_executable;
    logic              ift_tlb_supervisor;
    l1i_tag_t          ift_tag [L1I_WAYS];
    logic [L1I_WAYS-1:0] ift_valid;

    logic              ifd_update_lru_en;
    l1i_way_idx_t      ifd_update_lru_way;
    logic              ifd_cache_miss;
    logic              ifd_near_miss;
    cache_line_index_t ifd_cache_miss_paddr;
    local_thread_idx_t ifd_cache_miss_thread_idx;

    modport master (
        output ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
               ift_tlb_hit, ift_tlb_present, ift_tlb_executable, ift_tlb_supervisor,
               ift_tag, ift_valid,
        input  ifd_update_lru_en, ifd_update_lru_way, ifd_cache_miss, ifd_near_miss,
               ifd_cache_miss_paddr, ifd_cache_miss_thread_idx
    );

    modport slave (
        input  ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
               ift_tlb_hit, ift_tlb_present, ift_tlb_executable, ift_tlb_supervisor,
               ift_tag, ift_valid,
        output ifd_update_lru_en, ifd_update_lru_way, ifd_cache_miss, ifd_near_miss,
               ifd_cache_miss_paddr, ifd_cache_miss_thread_idx
    );

endinterface

// File: rtl/ifetch_data_stage_lib.sv
// Generic building blocks used by the data stage: a one-read/one-write SRAM
// and a one-hot to index encoder.

module sram_1r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 64,
    parameter bit NEW_DATA   = 1'b1,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    logic [DATA_WIDTH-1:0] mem [SIZE];

    // Storage array; contents are never reset, validity lives in the tags.
    always_ff @(posedge clk) begin
        if (write_en)
            mem[write_addr] <= write_data;
    end

    // Synchronous read; a same-address write is forwarded when NEW_DATA is set.
    always_ff @(posedge clk) begin
        if (read_en) begin
            if (NEW_DATA && write_en && write_addr == read_addr)
                read_data <= write_data;
            else
                read_data <= mem[read_addr];
        end
    end

endmodule

module oh_to_idx #(
    parameter int NUM_SIGNALS = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index
);

    // OR together the indices of set bits; exact when the input is one-hot.
    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot[i])
                index = index | INDEX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/ifetch_data_stage.sv
// Second instruction fetch stage: way tag compare, fault detection, miss and
// LRU feedback to the tag stage, and delivery of one instruction per cycle.
module ifetch_data_stage import ifetch_data_stage_pkg::*; (
    input  logic                        clk,
    input  logic                        reset,

    ifetch_data_stage_if.slave          ift,

    input  logic [THREADS_PER_CORE-1:0] cr_supervisor_en,

    input  logic                        wb_rollback_en,
    input  local_thread_idx_t           wb_rollback_thread_idx,

    input  logic                        l2i_idata_update_en,
    input  l1i_way_idx_t                l2i_idata_update_way,
    input  l1i_set_idx_t                l2i_idata_update_set,
    input  logic [CACHE_LINE_BITS-1:0]  l2i_idata_update_data,
    input  logic [L1I_WAYS-1:0]         l2i_itag_update_en,
    input  l1i_set_idx_t                l2i_itag_update_set,
    input  l1i_tag_t                    l2i_itag_update_tag,

    output logic                        ifd_instruction_valid,
    output logic [31:0]                 ifd_instruction,
    output logic [31:0]                 ifd_pc,
    output local_thread_idx_t           ifd_thread_idx,
    output logic                        ifd_alignment_fault,
    output logic                        ifd_tlb_miss,
    output logic                        ifd_page_fault,
    output logic                        ifd_supervisor_fault,
    output logic                        ifd_executable_fault,
    output logic                        ifd_perf_icache_hit,
    output logic                        ifd_perf_icache_miss,
    output logic                        ifd_perf_itlb_miss
);

    logic [L1I_WAYS-1:0]        way_hit;
    l1i_way_idx_t               hit_way;
    fetch_fault_t               fault_kind;
    logic                       fault;
    logic                       cache_hit;
    logic                       raw_miss;
    logic                       near_miss;
    logic                       rollback_this_thread;
    logic [CACHE_LINE_BITS-1:0] fetched_line;
    logic [31:0]                fetched_word;
    logic                       unused_offset_bits;

    logic [3:0]                 word_idx_q;
    logic [31:0]                pc_q;
    local_thread_idx_t          thread_q;
    fetch_fault_t               fault_q;
    logic                       valid_q;
    logic                       perf_hit_q;
    logic                       perf_miss_q;
    logic                       perf_itlb_q;

    // Compare every way's tag against the translated address.
    always_comb begin
        way_hit = '0;
        for (int w = 0; w < L1I_WAYS; w++)
            way_hit[w] = ift.ift_valid[w] && ift.ift_tag[w] == ift.ift_pc_paddr.tag;
    end

    oh_to_idx #(
        .NUM_SIGNALS(L1I_WAYS)
    ) u_hit_way (
        .one_hot(way_hit),
        .index  (hit_way)
    );

    assign fault_kind = classify_fault(
        ift.ift_pc_vaddr[1:0] != 2'b00,
        ift.ift_tlb_hit,
        ift.ift_tlb_present,
        ift.ift_tlb_supervisor && !cr_supervisor_en[ift.ift_thread_idx],
        ift.ift_tlb_executable);
    assign fault = fault_kind != FAULT_NONE;

    assign cache_hit = ift.ift_instruction_requested && !fault && |way_hit;
    assign raw_miss  = ift.ift_instruction_requested && !fault && !(|way_hit);

    // A line being filled right now for this address will hit on retry.
    assign near_miss = raw_miss && |l2i_itag_update_en
        && l2i_itag_update_set == ift.ift_pc_paddr.set_idx
        && l2i_itag_update_tag == ift.ift_pc_paddr.tag;

    assign ift.ifd_update_lru_en         = cache_hit;
    assign ift.ifd_update_lru_way        = hit_way;
    assign ift.ifd_near_miss             = near_miss;
    assign ift.ifd_cache_miss            = raw_miss && !near_miss;
    assign ift.ifd_cache_miss_paddr      = {ift.ift_pc_paddr.tag, ift.ift_pc_paddr.set_idx};
    assign ift.ifd_cache_miss_thread_idx = ift.ift_thread_idx;

    assign rollback_this_thread = wb_rollback_en && wb_rollback_thread_idx == ift.ift_thread_idx;
    assign unused_offset_bits   = ^ift.ift_pc_paddr.offset[1:0];

    sram_1r1w #(
        .DATA_WIDTH(CACHE_LINE_BITS),
        .SIZE      (L1I_WAYS * L1I_SETS),
        .NEW_DATA  (1'b1)
    ) u_data_sram (
        .clk       (clk),
        .read_en   (cache_hit),
        .read_addr ({hit_way, ift.ift_pc_paddr.set_idx}),
        .read_data (fetched_line),
        .write_en  (l2i_idata_update_en),
        .write_addr({l2i_idata_update_way, l2i_idata_update_set}),
        .write_data(l2i_idata_update_data)
    );

    // Valid and perf pulses must be clean out of reset; reset also drops any in-flight fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            perf_hit_q  <= 1'b0;
            perf_miss_q <= 1'b0;
            perf_itlb_q <= 1'b0;
        end else begin
            valid_q     <= ift.ift_instruction_requested && (cache_hit || fault) && !rollback_this_thread;
            perf_hit_q  <= cache_hit;
            perf_miss_q <= raw_miss && !near_miss;
            perf_itlb_q <= ift.ift_instruction_requested && !ift.ift_tlb_hit;
        end
    end

    // Payload flops only matter while valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        word_idx_q <= ift.ift_pc_paddr.offset[5:2];
        pc_q       <= ift.ift_pc_vaddr;
        thread_q   <= ift.ift_thread_idx;
        fault_q    <= ift.ift_instruction_requested ? fault_kind : FAULT_NONE;
    end

    // Word 0 sits in the most significant bits of the line; memory is big-endian.
    always_comb begin
        fetched_word    = fetched_line[(CACHE_LINE_WORDS - 1 - int'(word_idx_q)) * 32 +: 32];
        ifd_instruction = {fetched_word[7:0], fetched_word[15:8],
                           fetched_word[23:16], fetched_word[31:24]};
    end

    assign ifd_instruction_valid = valid_q;
    assign ifd_pc                = pc_q;
    assign ifd_thread_idx        = thread_q;
    assign ifd_alignment_fault   = fault_q == FAULT_ALIGNMENT;
    assign ifd_tlb_miss          = fault_q == FAULT_TLB_MISS;
    assign ifd_page_fault        = fault_q == FAULT_PAGE;
    assign ifd_supervisor_fault  = fault_q == FAULT_SUPERVISOR;
    assign ifd_executable_fault  = fault_q == FAULT_EXECUTABLE;
    assign ifd_perf_icache_hit   = perf_hit_q;
    assign ifd_perf_icache_miss  = perf_miss_q;
    assign ifd_perf_itlb_miss    = perf_itlb_q;

endmodule

// File: tb/tb_ifetch_data_stage.sv
// Randomized and directed checks of ifetch_data_stage against a line-level
// reference model of the cache data and fault rules.
module tb_ifetch_data_stage;
    import ifetch_data_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ifetch_data_stage_if ift_bus();

    logic [THREADS_PER_CORE-1:0] cr_supervisor_en;
    logic                        wb_rollback_en;
    local_thread_idx_t           wb_rollback_thread_idx;
    logic                        l2i_idata_update_en;
    l1i_way_idx_t                l2i_idata_update_way;
    l1i_set_idx_t                l2i_idata_update_set;
    logic [CACHE_LINE_BITS-1:0]  l2i_idata_update_data;
    logic [L1I_WAYS-1:0]         l2i_itag_update_en;
    l1i_set_idx_t                l2i_itag_update_set;
    l1i_tag_t                    l2i_itag_update_tag;

    logic              ifd_instruction_valid;
    logic [31:0]       ifd_instruction;
    logic [31:0]       ifd_pc;
    local_thread_idx_t ifd_thread_idx;
    logic ifd_alignment_fault, ifd_tlb_miss, ifd_page_fault;
    logic ifd_supervisor_fault, ifd_executable_fault;
    logic ifd_perf_icache_hit, ifd_perf_icache_miss, ifd_perf_itlb_miss;

    ifetch_data_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .ift                   (ift_bus),
        .cr_supervisor_en      (cr_supervisor_en),
        .wb_rollback_en        (wb_rollback_en),
        .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .l2i_idata_update_en   (l2i_idata_update_en),
        .l2i_idata_update_way  (l2i_idata_update_way),
        .l2i_idata_update_set  (l2i_idata_update_set),
        .l2i_idata_update_data (l2i_idata_update_data),
        .l2i_itag_update_en    (l2i_itag_update_en),
        .l2i_itag_update_set   (l2i_itag_update_set),
        .l2i_itag_update_tag   (l2i_itag_update_tag),
        .ifd_instruction_valid (ifd_instruction_valid),
        .ifd_instruction       (ifd_instruction),
        .ifd_pc                (ifd_pc),
        .ifd_thread_idx        (ifd_thread_idx),
        .ifd_alignment_fault   (ifd_alignment_fault),
        .ifd_tlb_miss          (ifd_tlb_miss),
        .ifd_page_fault        (ifd_page_fault),
        .ifd_supervisor_fault  (ifd_supervisor_fault),
        .ifd_executable_fault  (ifd_executable_fault),
        .ifd_perf_icache_hit   (ifd_perf_icache_hit),
        .ifd_perf_icache_miss  (ifd_perf_icache_miss),
        .ifd_perf_itlb_miss    (ifd_perf_itlb_miss)
    );

    typedef struct packed {
        logic                                  req;
        l1i_tag_t                              tag;
        l1i_set_idx_t                          set;
        logic [31:0]                           vaddr;
        local_thread_idx_t                     thread;
        logic                                  tlb_hit;
        logic                                  present;
        logic                                  exec;
        logic                                  sup;
        logic [L1I_WAYS-1:0][L1I_TAG_WIDTH-1:0] way_tag;
        logic [L1I_WAYS-1:0]                   way_valid;
        logic [THREADS_PER_CORE-1:0]           sup_en;
        logic                                  rb_en;
        local_thread_idx_t                     rb_thread;
        logic                                  dfill;
        l1i_way_idx_t                          dway;
        l1i_set_idx_t                          dset;
        logic [CACHE_LINE_BITS-1:0]            ddata;
        logic [L1I_WAYS-1:0]                   tfill_en;
        l1i_set_idx_t                          tset;
        l1i_tag_t                              ttag;
    } stim_t;

    int checks = 0;
    int errors = 0;

    logic [CACHE_LINE_BITS-1:0] ref_mem [L1I_WAYS][L1I_SETS];

    logic        exp_valid = 1'b0;
    logic        exp_instr_known = 1'b0;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [1:0]  exp_thread;
    logic [4:0]  exp_flags;
    logic [2:0]  exp_perf = 3'b000;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [CACHE_LINE_BITS-1:0] rand_line();
        logic [CACHE_LINE_BITS-1:0] ln;
        for (int i = 0; i < CACHE_LINE_WORDS; i++)
            ln[i*32 +: 32] = $urandom;
        return ln;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s = '0;
        s.tlb_hit = 1'b1;
        s.present = 1'b1;
        s.exec    = 1'b1;
        return s;
    endfunction

    // Request whose only matching valid way is 'way'; other ways carry foreign tags.
    function automatic stim_t hit_stim(input l1i_tag_t tag, input l1i_set_idx_t set,
                                       input logic [5:0] off, input int way,
                                       input local_thread_idx_t thread);
        stim_t s = idle_stim();
        s.req    = 1'b1;
        s.tag    = tag;
        s.set    = set;
        s.thread = thread;
        s.vaddr  = {20'h0ABCD, set, off};
        for (int w = 0; w < L1I_WAYS; w++)
            s.way_tag[w] = tag ^ L1I_TAG_WIDTH'(w + 1);
        s.way_valid = '1;
        if (way >= 0)
            s.way_tag[way] = tag;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle_stim();
        s.req    = $urandom_range(0, 7) != 0;
        s.tag    = L1I_TAG_WIDTH'($urandom);
        s.set    = L1I_SET_IDX_WIDTH'($urandom);
        s.thread = THREAD_IDX_WIDTH'($urandom);
        s.vaddr  = {20'($urandom), s.set, 4'($urandom), 2'b00};
        if ($urandom_range(0, 7) == 0)
            s.vaddr[1:0] = 2'($urandom_range(1, 3));
        s.tlb_hit = $urandom_range(0, 9) != 0;
        s.present = $urandom_range(0, 9) != 0;
        s.exec    = $urandom_range(0, 9) != 0;
        s.sup     = $urandom_range(0, 3) == 0;
        s.sup_en  = 4'($urandom);
        for (int w = 0; w < L1I_WAYS; w++)
            s.way_tag[w] = s.tag ^ L1I_TAG_WIDTH'($urandom_range(1, 20'hFFFFF));
        s.way_valid = 4'($urandom);
        if ($urandom_range(0, 9) < 6) begin
            int way = $urandom_range(0, L1I_WAYS - 1);
            s.way_tag[way]   = s.tag;
            s.way_valid[way] = 1'b1;
        end
        s.rb_en     = $urandom_range(0, 3) == 0;
        s.rb_thread = THREAD_IDX_WIDTH'($urandom);
        s.dfill     = $urandom_range(0, 3) == 0;
        s.dway      = L1I_WAY_IDX_WIDTH'($urandom);
        s.dset      = $urandom_range(0, 1) != 0 ? s.set : L1I_SET_IDX_WIDTH'($urandom);
        s.ddata     = rand_line();
        if ($urandom_range(0, 3) == 0)
            s.tfill_en = 4'($urandom_range(1, 15));
        s.tset = $urandom_range(0, 1) != 0 ? s.set : L1I_SET_IDX_WIDTH'($urandom);
        s.ttag = $urandom_range(0, 1) != 0 ? s.tag : L1I_TAG_WIDTH'($urandom);
        return s;
    endfunction

    task automatic checkRegistered();
        checkOutput("valid", {63'b0, ifd_instruction_valid}, {63'b0, exp_valid});
        checkOutput("perf", {61'b0, ifd_perf_icache_hit, ifd_perf_icache_miss, ifd_perf_itlb_miss},
                    {61'b0, exp_perf});
        if (exp_valid) begin
            checkOutput("pc", {32'b0, ifd_pc}, {32'b0, exp_pc});
            checkOutput("thread", {62'b0, ifd_thread_idx}, {62'b0, exp_thread});
            checkOutput("flags", {59'b0, ifd_alignment_fault, ifd_tlb_miss, ifd_page_fault,
                                  ifd_supervisor_fault, ifd_executable_fault},
                        {59'b0, exp_flags});
            if (exp_instr_known)
                checkOutput("instruction", {32'b0, ifd_instruction}, {32'b0, exp_instr});
        end
    endtask

    // One cycle: check last cycle's delivery, drive, check feedback, predict next delivery.
    task automatic applyStimulus(input stim_t s);
        logic [4:0]  flags;
        logic        found;
        int          way;
        logic        hit, raw, near;
        logic [CACHE_LINE_BITS-1:0] line;
        logic [31:0] word;
        int          word_idx;

        @(negedge clk);
        checkRegistered();

        ift_bus.ift_instruction_requested = s.req;
        ift_bus.ift_pc_paddr              = {s.tag, s.set, s.vaddr[5:0]};
        ift_bus.ift_pc_vaddr              = s.vaddr;
        ift_bus.ift_thread_idx            = s.thread;
        ift_bus.ift_tlb_hit               = s.tlb_hit;
        ift_bus.ift_tlb_present           = s.present;
        ift_bus.ift_tlb_executable        = s.exec;
        ift_bus.ift_tlb_supervisor        = s.sup;
        for (int w = 0; w < L1I_WAYS; w++)
            ift_bus.ift_tag[w] = s.way_tag[w];
        ift_bus.ift_valid      = s.way_valid;
        cr_supervisor_en       = s.sup_en;
        wb_rollback_en         = s.rb_en;
        wb_rollback_thread_idx = s.rb_thread;
        l2i_idata_update_en    = s.dfill;
        l2i_idata_update_way   = s.dway;
        l2i_idata_update_set   = s.dset;
        l2i_idata_update_data  = s.ddata;
        l2i_itag_update_en     = s.tfill_en;
        l2i_itag_update_set    = s.tset;
        l2i_itag_update_tag    = s.ttag;
        #1;

        if (s.vaddr[1:0] != 2'b00)                   flags = 5'b10000;
        else if (!s.tlb_hit)                         flags = 5'b01000;
        else if (!s.present)                         flags = 5'b00100;
        else if (s.sup && !s.sup_en[s.thread])       flags = 5'b00010;
        else if (!s.exec)                            flags = 5'b00001;
        else                                         flags = 5'b00000;

        found = 1'b0;
        way   = 0;
        for (int w = 0; w < L1I_WAYS; w++) begin
            if (s.way_valid[w] && s.way_tag[w] == s.tag) begin
                found = 1'b1;
                way   = w;
            end
        end

        hit  = s.req && flags == 0 && found;
        raw  = s.req && flags == 0 && !found;
        near = raw && s.tfill_en != 0 && s.tset == s.set && s.ttag == s.tag;

        checkOutput("lru_en", {63'b0, ift_bus.ifd_update_lru_en}, {63'b0, hit});
        if (hit)
            checkOutput("lru_way", {62'b0, ift_bus.ifd_update_lru_way}, 64'(way));
        checkOutput("cache_miss", {63'b0, ift_bus.ifd_cache_miss}, {63'b0, raw && !near});
        checkOutput("near_miss", {63'b0, ift_bus.ifd_near_miss}, {63'b0, near});
        if (raw) begin
            checkOutput("miss_paddr", {38'b0, ift_bus.ifd_cache_miss_paddr}, {38'b0, s.tag, s.set});
            checkOutput("miss_thread", {62'b0, ift_bus.ifd_cache_miss_thread_idx}, {62'b0, s.thread});
        end

        if (s.dfill)
            ref_mem[s.dway][s.dset] = s.ddata;

        exp_valid       = s.req && (hit || flags != 0) && !(s.rb_en && s.rb_thread == s.thread);
        exp_instr_known = hit;
        if (hit) begin
            line      = ref_mem[way][s.set];
            word_idx  = int'(s.vaddr[5:2]);
            word      = 32'(line >> (32 * (CACHE_LINE_WORDS - 1 - word_idx)));
            exp_instr = {<<8{word}};
        end
        exp_pc     = s.vaddr;
        exp_thread = s.thread;
        exp_flags  = flags;
        exp_perf   = {hit, raw && !near, s.req && !s.tlb_hit};
    endtask

    initial begin
        stim_t st;
        logic [CACHE_LINE_BITS-1:0] ln;

        reset = 1'b1;
        st = idle_stim();
        ift_bus.ift_instruction_requested = 1'b0;
        ift_bus.ift_pc_paddr   = '0;
        ift_bus.ift_pc_vaddr   = '0;
        ift_bus.ift_thread_idx = '0;
        ift_bus.ift_tlb_hit = 1'b1;
        ift_bus.ift_tlb_present = 1'b1;
        ift_bus.ift_tlb_executable = 1'b1;
        ift_bus.ift_tlb_supervisor = 1'b0;
        for (int w = 0; w < L1I_WAYS; w++)
            ift_bus.ift_tag[w] = '0;
        ift_bus.ift_valid = '0;
        cr_supervisor_en = '0;
        wb_rollback_en = 1'b0;
        wb_rollback_thread_idx = '0;
        l2i_idata_update_en = 1'b0;
        l2i_idata_update_way = '0;
        l2i_idata_update_set = '0;
        l2i_idata_update_data = '0;
        l2i_itag_update_en = '0;
        l2i_itag_update_set = '0;
        l2i_itag_update_tag = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {63'b0, ifd_instruction_valid}, 64'd0);
        checkOutput("reset_perf", {61'b0, ifd_perf_icache_hit, ifd_perf_icache_miss, ifd_perf_itlb_miss}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Give every line known contents before any hit reads it.
        for (int w = 0; w < L1I_WAYS; w++) begin
            for (int s = 0; s < L1I_SETS; s++) begin
                st = idle_stim();
                st.dfill = 1'b1;
                st.dway  = L1I_WAY_IDX_WIDTH'(w);
                st.dset  = L1I_SET_IDX_WIDTH'(s);
                st.ddata = rand_line();
                applyStimulus(st);
            end
        end

        $display("[TB] directed hit on way 2");
        ln = rand_line();
        ln[447 -: 32] = 32'h11223344;
        st = idle_stim();
        st.dfill = 1'b1; st.dway = 2'd2; st.dset = 6'd3; st.ddata = ln;
        applyStimulus(st);
        applyStimulus(hit_stim(20'h01234, 6'd3, 6'h08, 2, 2'd1));
        checkOutput("tp_lru_way", {62'b0, ift_bus.ifd_update_lru_way}, 64'd2);
        applyStimulus(idle_stim());
        checkOutput("tp_instr", {32'b0, ifd_instruction}, 64'h44332211);

        $display("[TB] directed miss and near miss");
        applyStimulus(hit_stim(20'h05555, 6'd9, 6'h04, -1, 2'd3));
        checkOutput("tp_miss", {63'b0, ift_bus.ifd_cache_miss}, 64'd1);
        st = hit_stim(20'h05555, 6'd9, 6'h04, -1, 2'd2);
        st.tfill_en = 4'b0100; st.tset = 6'd9; st.ttag = 20'h05555;
        applyStimulus(st);
        checkOutput("tp_near", {63'b0, ift_bus.ifd_near_miss}, 64'd1);

        $display("[TB] directed faults");
        st = hit_stim(20'h01234, 6'd3, 6'h02, 2, 2'd0);
        st.vaddr = 32'h00001002;
        applyStimulus(st);
        st = hit_stim(20'h01234, 6'd3, 6'h08, 2, 2'd0);
        st.sup = 1'b1; st.sup_en = 4'b0000;
        applyStimulus(st);
        checkOutput("tp_align", {63'b0, ifd_alignment_fault}, 64'd1);

        $display("[TB] directed rollback");
        st = hit_stim(20'h01234, 6'd3, 6'h08, 2, 2'd1);
        st.rb_en = 1'b1; st.rb_thread = 2'd1;
        applyStimulus(st);
        st.rb_thread = 2'd3;
        applyStimulus(st);

        $display("[TB] directed fill during read");
        st = hit_stim(20'h00777, 6'd5, 6'h3C, 1, 2'd2);
        st.dfill = 1'b1; st.dway = 2'd1; st.dset = 6'd5; st.ddata = rand_line();
        applyStimulus(st);
        applyStimulus(idle_stim());

        $display("[TB] reset during in-flight fetch");
        applyStimulus(hit_stim(20'h01234, 6'd3, 6'h10, 2, 2'd0));
        @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", {63'b0, ifd_instruction_valid}, 64'd1);
        reset = 1'b1;
        ift_bus.ift_instruction_requested = 1'b0;
        #1;
        checkOutput("mid_reset_valid", {63'b0, ifd_instruction_valid}, 64'd0);
        exp_valid = 1'b0;
        exp_perf  = 3'b000;
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus(rand_stim());
        applyStimulus(idle_stim());
        @(negedge clk);
        checkRegistered();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
